// File: rtl/code_lock_ctrl_if.sv
// Code-entry port bundle for code_lock_ctrl.
// master drives the debounced key inputs; slave is the lock controller.
interface code_lock_ctrl_if #(
    parameter int CODE_LEN = 4
);
    localparam int CNT_W = $clog2(CODE_LEN + 1);

    logic             in_data;
    logic             in_en;
    logic             in_clear;
    logic             out_ready;
    logic             out_shift;
    logic [CNT_W-1:0] out_cnt;
    logic             out_unlock;
    logic             out_error;
    logic             out_alarm;

    modport master (
        output in_data, in_en, in_clear,
        input  out_ready, out_shift, out_cnt, out_unlock, out_error, out_alarm
    );

    modport slave (
        input  in_data, in_en, in_clear,
        output out_ready, out_shift, out_cnt, out_unlock, out_error, out_alarm
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// Serial code-entry lock controller.
// Collects CODE_LEN bits (first bit ends up in the MSB), compares against CODE,
// then either opens for OPEN_CYCLES, flags a single-cycle error, or after
// MAX_FAIL consecutive mismatches enters an alarmed lockout for LOCK_CYCLES.
module code_lock_ctrl #(
    parameter int                  CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  OPEN_CYCLES = 8,
    parameter int                  LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    code_lock_ctrl_if.slave  bus
);
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

    localparam logic [CNT_W-1:0]  CNT_PRELAST = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_PRELAST = FAIL_W'(MAX_FAIL - 1);
    // Timers are loaded with N-1 and the state is left when they read zero,
    // so the state (and its output) lasts exactly N cycles.
    localparam logic [TMR_W-1:0]  OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t              state;
    logic [CODE_LEN-1:0] sr;
    logic [CNT_W-1:0]    cnt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    timer;
    logic                shift_q;
    // {ready, unlock, error, alarm}, registered alongside the state they decode
    logic [3:0]          flags_q;

    // Moore decode of a state into its output flags.
    function automatic logic [3:0] flags_of(input state_t s);
        logic [3:0] f;
        f = '0;
        unique case (s)
            S_IDLE, S_ENTRY: f = 4'b1000;
            S_OPEN:          f = 4'b0100;
            S_FAIL:          f = 4'b0010;
            S_LOCKOUT:       f = 4'b0001;
            default:         f = 4'b0000;
        endcase
        return f;
    endfunction

    // Controller FSM: entry shift register, check, open/fail/lockout timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sr       <= '0;
            cnt      <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            shift_q  <= 1'b0;
            flags_q  <= flags_of(S_IDLE);
        end else begin
            shift_q <= 1'b0;
            unique case (state)
                S_IDLE, S_ENTRY: begin
                    if (bus.in_en && !bus.in_clear) begin
                        sr      <= {sr[CODE_LEN-2:0], bus.in_data};
                        cnt     <= cnt + CNT_W'(1);
                        shift_q <= 1'b1;
                        if (cnt == CNT_PRELAST) begin
                            state   <= S_CHECK;
                            flags_q <= flags_of(S_CHECK);
                        end else begin
                            state   <= S_ENTRY;
                            flags_q <= flags_of(S_ENTRY);
                        end
                    end else if (bus.in_clear && state == S_ENTRY) begin
                        state   <= S_IDLE;
                        flags_q <= flags_of(S_IDLE);
                        cnt     <= '0;
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (sr == CODE) begin
                        state    <= S_OPEN;
                        flags_q  <= flags_of(S_OPEN);
                        fail_cnt <= '0;
                        timer    <= OPEN_LOAD;
                    end else if (fail_cnt == FAIL_PRELAST) begin
                        state    <= S_LOCKOUT;
                        flags_q  <= flags_of(S_LOCKOUT);
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                        timer    <= LOCK_LOAD;
                    end else begin
                        state    <= S_FAIL;
                        flags_q  <= flags_of(S_FAIL);
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                    end
                end
                S_OPEN: begin
                    if (timer == '0) begin
                        state   <= S_IDLE;
                        flags_q <= flags_of(S_IDLE);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_FAIL: begin
                    state   <= S_IDLE;
                    flags_q <= flags_of(S_IDLE);
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= S_IDLE;
                        flags_q  <= flags_of(S_IDLE);
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    flags_q <= flags_of(S_IDLE);
                    cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.out_ready  = flags_q[3];
    assign bus.out_unlock = flags_q[2];
    assign bus.out_error  = flags_q[1];
    assign bus.out_alarm  = flags_q[0];
    assign bus.out_shift  = shift_q;
    assign bus.out_cnt    = cnt;
endmodule
